// File: rtl/matmul_serial_scheduler.sv
// matmul_serial_scheduler
//   Shares one bit-serial matrix_multiplier engine between NREQ requesters.
//   A round-robin arbiter picks a requester in IDLE, its operand words are
//   latched and shifted LSB-first into the engine (mm_start marks bit 0),
//   the strobed serial result is collected LSB-first, and the result is
//   returned to the granted requester over a one-hot valid/ready response.
//   A watchdog aborts the collection with rsp_err=1 / rsp_data=0 when the
//   engine stays silent for too long.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both high. req_ready is combinational and only asserted in IDLE for
//   the arbitration winner; rsp_valid holds with stable rsp_data/rsp_err
//   until the addressed requester raises rsp_ready.
//
// Ports
//   clk, NRST                 clock, asynchronous active-low reset
//   req_valid/req_ready       per-requester request handshake (ready one-hot)
//   req_a/req_b               operand words, requester i at [i*OPW +: OPW]
//   rsp_valid/rsp_ready       per-requester response handshake (valid one-hot)
//   rsp_data/rsp_err          shared result bus, timeout flag
//   mm_start/mm_a/mm_b        serial operand stream to the engine
//   mm_out/mm_out_strobe      serial result stream from the engine
//   busy                      FSM not in IDLE
//   dbg_state                 current FSM state encoding
module matmul_serial_scheduler #(
  parameter int NREQ    = 2,
  parameter int OPW     = 16,
  parameter int RESW    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 NRST,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OPW-1:0]  req_a,
  input  logic [NREQ*OPW-1:0]  req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [RESW-1:0]      rsp_data,
  output logic                 rsp_err,
  output logic                 mm_start,
  output logic                 mm_a,
  output logic                 mm_b,
  input  logic                 mm_out,
  input  logic                 mm_out_strobe,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int OCW = $clog2(OPW + 1);
  localparam int RCW = $clog2(RESW + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [OCW-1:0] OP_LAST  = OCW'(OPW);
  localparam logic [RCW-1:0] RES_LAST = RCW'(RESW - 1);
  localparam logic [TW-1:0]  TO_MAX   = TW'(TIMEOUT);
  localparam logic [IW-1:0]  IDX_LAST = IW'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_WAIT    = 3'd2,
    S_COLLECT = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   rr_q;
  logic [IW-1:0]   grant_q;
  logic [OPW-1:0]  sh_a_q;
  logic [OPW-1:0]  sh_b_q;
  logic [OCW-1:0]  op_cnt_q;
  logic [RESW-1:0] res_q;
  logic [RCW-1:0]  res_cnt_q;
  logic [TW-1:0]   to_cnt_q;
  logic            err_q;
  logic            mm_start_q;
  logic            mm_a_q;
  logic            mm_b_q;

  // Unpack the flattened operand buses so the winner can be indexed directly.
  logic [OPW-1:0] a_arr [NREQ];
  logic [OPW-1:0] b_arr [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*OPW +: OPW];
    assign b_arr[g] = req_b[g*OPW +: OPW];
  end

  // Round-robin search starting at rr_q with wrap-around.
  logic          win_valid;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (int'(rr_q) + k >= NREQ) cand = IW'(int'(rr_q) + k - NREQ);
      else                        cand = IW'(int'(rr_q) + k);
      if (!win_valid && req_valid[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  logic [OPW-1:0] a_sel;
  logic [OPW-1:0] b_sel;
  logic [IW-1:0]  rr_d;
  assign a_sel = a_arr[win_idx];
  assign b_sel = b_arr[win_idx];
  assign rr_d  = (win_idx == IDX_LAST) ? '0 : win_idx + IW'(1);

  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      grant_q    <= '0;
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      op_cnt_q   <= '0;
      res_q      <= '0;
      res_cnt_q  <= '0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
      mm_start_q <= 1'b0;
      mm_a_q     <= 1'b0;
      mm_b_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_valid) begin
            state_q    <= S_SHIFT;
            grant_q    <= win_idx;
            rr_q       <= rr_d;
            // Bit 0 goes out on the first SHIFT cycle together with start.
            mm_start_q <= 1'b1;
            mm_a_q     <= a_sel[0];
            mm_b_q     <= b_sel[0];
            sh_a_q     <= a_sel >> 1;
            sh_b_q     <= b_sel >> 1;
            op_cnt_q   <= OCW'(1);
            res_q      <= '0;
            res_cnt_q  <= '0;
            err_q      <= 1'b0;
          end
        end
        S_SHIFT: begin
          mm_start_q <= 1'b0;
          // op_cnt_q counts bits already placed on mm_a/mm_b.
          if (op_cnt_q == OP_LAST) begin
            state_q  <= S_WAIT;
            mm_a_q   <= 1'b0;
            mm_b_q   <= 1'b0;
            to_cnt_q <= '0;
          end else begin
            mm_a_q   <= sh_a_q[0];
            mm_b_q   <= sh_b_q[0];
            sh_a_q   <= sh_a_q >> 1;
            sh_b_q   <= sh_b_q >> 1;
            op_cnt_q <= op_cnt_q + OCW'(1);
          end
        end
        S_WAIT, S_COLLECT: begin
          // A strobe always beats the timeout, even on the boundary cycle.
          if (mm_out_strobe) begin
            // Shifting in at the MSB leaves the first bit at index 0 once
            // all RESW bits have arrived.
            res_q     <= {mm_out, res_q[RESW-1:1]};
            res_cnt_q <= res_cnt_q + RCW'(1);
            to_cnt_q  <= '0;
            state_q   <= (res_cnt_q == RES_LAST) ? S_RESP : S_COLLECT;
          end else if (to_cnt_q == TO_MAX) begin
            state_q <= S_RESP;
            err_q   <= 1'b1;
            res_q   <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready[grant_q]) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Ready is gated by reset so nothing looks accepted while NRST is low.
  always_comb begin
    req_ready = '0;
    if (NRST && state_q == S_IDLE && win_valid) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == S_RESP) rsp_valid[grant_q] = 1'b1;
  end

  assign rsp_data  = res_q;
  assign rsp_err   = err_q;
  assign mm_start  = mm_start_q;
  assign mm_a      = mm_a_q;
  assign mm_b      = mm_b_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_matmul_serial_scheduler.sv
// Testbench for matmul_serial_scheduler: table of transactions plus
// hand-written sequences for arbitration, backpressure and reset abort.
// Expected responses are queued when a request is accepted and checked by a
// response monitor when the DUT completes the handshake.
module tb_matmul_serial_scheduler;

  localparam int NREQ    = 2;
  localparam int OPW     = 16;
  localparam int RESW    = 32;
  localparam int TIMEOUT = 255;
  localparam int EW      = 3 + 1 + RESW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic NRST = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_a = '0;
  logic [NREQ*OPW-1:0] req_b = '0;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready = '1;
  logic [RESW-1:0]     rsp_data;
  logic                rsp_err;
  logic                mm_start, mm_a, mm_b;
  logic                mm_out = 1'b0;
  logic                mm_out_strobe = 1'b0;
  logic                busy;
  logic [2:0]          dbg_state;

  matmul_serial_scheduler #(
    .NREQ(NREQ), .OPW(OPW), .RESW(RESW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .NRST(NRST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
    .mm_out(mm_out), .mm_out_strobe(mm_out_strobe),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] oh_idx(input logic [NREQ-1:0] v);
    case (v)
      2'b01:   oh_idx = 3'd0;
      2'b10:   oh_idx = 3'd1;
      default: oh_idx = 3'd7;
    endcase
  endfunction

  // Response monitor: samples well after the bench drives at the falling edge.
  always @(negedge clk) begin
    #3;
    if (NRST && (rsp_valid & rsp_ready) != '0) begin
      logic [EW-1:0] act;
      act = {oh_idx(rsp_valid), rsp_err, rsp_data};
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'(act), 64'(0) | (64'(1) << 63));
      end else begin
        check("rsp", 64'(act), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic request(input int idx, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                         output bit ok);
    req_a[idx*OPW +: OPW] = a;
    req_b[idx*OPW +: OPW] = b;
    req_valid[idx] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      #1;
      if (req_ready[idx]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("grant", 64'(req_ready), 64'(1) << idx);
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
      req_valid[idx] = 1'b0;
    end
  endtask

  // Engine model. Entered at the falling edge of the first SHIFT cycle.
  task automatic serve(input int idx, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                       input logic [RESW-1:0] res, input int gap, input int first_dly,
                       input bit to, input bit noise, input bit check_lat);
    logic [OPW-1:0] ca, cb, cs;
    int cnt;
    for (int k = 0; k < OPW; k++) begin
      if (noise) begin mm_out_strobe = 1'b1; mm_out = 1'b1; end
      #1;
      ca[k] = mm_a; cb[k] = mm_b; cs[k] = mm_start;
      @(negedge clk);
    end
    mm_out_strobe = 1'b0;
    mm_out = 1'b0;
    #1;
    check("shift_a", 64'(ca), 64'(a));
    check("shift_b", 64'(cb), 64'(b));
    check("start_bit0_only", 64'(cs), 64'(1));
    check("ops_zero_in_wait", 64'({mm_start, mm_a, mm_b, busy}), 64'(4'b0001));
    if (to) begin
      cnt = 0;
      while (!rsp_valid[idx] && cnt < 400) begin
        @(negedge clk);
        #1;
        cnt++;
      end
      check("timeout_latency", 64'(cnt), 64'(TIMEOUT + 1));
    end else begin
      repeat (first_dly) @(negedge clk);
      for (int j = 0; j < RESW; j++) begin
        mm_out_strobe = 1'b1;
        mm_out = res[j];
        @(negedge clk);
        mm_out_strobe = 1'b0;
        mm_out = 1'b0;
        if (j < RESW - 1) repeat (gap) @(negedge clk);
      end
      if (check_lat) begin
        #1;
        check("rsp_latency", 64'(rsp_valid), 64'(1) << idx);
      end
    end
  endtask

  task automatic do_txn(input int idx, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                        input logic [RESW-1:0] res, input int gap, input int first_dly,
                        input bit to, input bit noise, input logic exp_err,
                        input logic [RESW-1:0] exp_data);
    bit ok;
    request(idx, a, b, ok);
    if (ok) begin
      exp_q.push_back({3'(idx), exp_err, exp_data});
      serve(idx, a, b, res, gap, first_dly, to, noise, 1'b1);
    end
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    int              idx;
    logic [OPW-1:0]  a;
    logic [OPW-1:0]  b;
    logic [RESW-1:0] res;
    int              gap;
    int              first_dly;
    bit              to;
    bit              noise;
    logic            exp_err;
    logic [RESW-1:0] exp_data;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [RESW-1:0] r;
    logic [OPW-1:0]  a0, a1, b0, b1;
    int              w;
    bit              got, ok;

    // reset values
    repeat (3) @(negedge clk);
    #1;
    check("reset_outs", 64'({req_ready, rsp_valid, rsp_data, rsp_err, mm_start, mm_a, mm_b, busy}), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(0));
    @(negedge clk);
    NRST = 1'b1;
    @(negedge clk);
    #1;
    check("idle_no_ready", 64'({req_ready, busy}), 64'(0));
    @(negedge clk);

    // idx, a, b, res, gap, first_dly, to, noise, exp_err, exp_data
    tbl[0] = '{0, 16'h00A5, 16'h0003, 32'h12345678, 0, 1, 1'b0, 1'b0, 1'b0, 32'h12345678};
    r = $urandom;
    tbl[1] = '{1, 16'($urandom), 16'($urandom), r, 0, 1, 1'b0, 1'b1, 1'b0, r};
    r = $urandom;
    tbl[2] = '{0, 16'($urandom), 16'($urandom), r, 3, 1, 1'b0, 1'b0, 1'b0, r};
    r = $urandom;
    tbl[3] = '{1, 16'($urandom), 16'($urandom), r, 0, 1, 1'b1, 1'b0, 1'b1, 32'h0};
    r = $urandom;
    tbl[4] = '{1, 16'($urandom), 16'($urandom), r, 0, 1, 1'b0, 1'b0, 1'b0, r};
    r = $urandom;
    tbl[5] = '{0, 16'($urandom), 16'($urandom), r, 0, TIMEOUT, 1'b0, 1'b0, 1'b0, r};
    r = $urandom;
    tbl[6] = '{0, 16'($urandom), 16'($urandom), r, $urandom_range(0, 2), $urandom_range(1, 4),
               1'b0, 1'b0, 1'b0, r};

    for (int i = 0; i < 7; i++) begin
      do_txn(tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].gap, tbl[i].first_dly,
             tbl[i].to, tbl[i].noise, tbl[i].exp_err, tbl[i].exp_data);
    end
    @(negedge clk);
    @(negedge clk);

    // Make sure the pointer starts at 0: grant requester 1 alone first.
    do_txn(1, 16'h0F0F, 16'hF0F0, 32'hCAFEF00D, 0, 1, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D);
    @(negedge clk);
    @(negedge clk);

    // both requesters valid continuously -> grants alternate 0,1,0,1
    a0 = 16'($urandom); a1 = 16'($urandom); b0 = 16'($urandom); b1 = 16'($urandom);
    req_a = {a1, a0};
    req_b = {b1, b0};
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      got = 1'b0;
      for (int t = 0; t < 400; t++) begin
        #1;
        if (req_ready != '0) begin got = 1'b1; break; end
        @(negedge clk);
      end
      check("alt_grant", 64'(req_ready), 64'(1) << (i % 2));
      if (!got) break;
      w = (req_ready == 2'b10) ? 1 : 0;
      exp_q.push_back({3'(w), 1'b0, r});
      @(posedge clk);
      @(negedge clk);
      serve(w, (w == 1) ? a1 : a0, (w == 1) ? b1 : b0, r, 0, 1, 1'b0, 1'b0, 1'b1);
    end
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);

    // backpressure: rsp_ready[0] low for 10 cycles, requester 1 waits
    rsp_ready = 2'b10;
    r = $urandom;
    a0 = 16'($urandom); b0 = 16'($urandom);
    request(0, a0, b0, ok);
    if (ok) begin
      exp_q.push_back({3'd0, 1'b0, r});
      serve(0, a0, b0, r, 0, 1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      req_a[OPW +: OPW] = 16'h5A5A;
      req_b[OPW +: OPW] = 16'hA5A5;
      req_valid[1] = 1'b1;
      for (int c = 0; c < 10; c++) begin
        #1;
        check("bp_valid", 64'(rsp_valid), 64'(2'b01));
        check("bp_data", 64'({rsp_err, rsp_data}), 64'({1'b0, r}));
        check("bp_no_accept", 64'(req_ready), 64'(0));
        @(negedge clk);
      end
      rsp_ready = 2'b11;
      r = $urandom;
      do_txn(1, 16'h5A5A, 16'hA5A5, r, 0, 1, 1'b0, 1'b0, 1'b0, r);
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);

    // reset in the middle of SHIFT: abort, then re-grant from rr = 0
    a0 = 16'h1357; b0 = 16'h2468;
    request(0, a0, b0, ok);
    repeat (5) @(negedge clk);
    NRST = 1'b0;
    req_a[OPW +: OPW] = 16'h7777;
    req_valid = 2'b11;
    #1;
    check("midrst_outs", 64'({req_ready, rsp_valid, rsp_data, rsp_err, mm_start, mm_a, mm_b, busy}), 64'(0));
    check("midrst_state", 64'(dbg_state), 64'(0));
    @(negedge clk);
    @(negedge clk);
    NRST = 1'b1;
    #1;
    check("rr_after_reset", 64'(req_ready), 64'(2'b01));
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    r = $urandom;
    exp_q.push_back({3'd0, 1'b0, r});
    serve(0, a0, b0, r, 0, 1, 1'b0, 1'b0, 1'b1);

    repeat (4) @(negedge clk);
    #4;
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    check("final_idle", 64'({busy, rsp_valid}), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
